// File: rtl/async_arb_m.sv
// rtl/async_arb_m.sv - round-robin arbiter sequencing one shared async_man_m handshake stage
//
// Purpose:
//   Shares one async_man_m stage between N_REQ clocked requesters. After reset
//   the stage is held in reset for INIT_CYCLES cycles. Each granted requester
//   then gets one full 4-phase return-to-zero handshake on the stage's left
//   channel. Its done_o bit pulses when the handshake has returned to zero.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   req_i         in   [N_REQ] level requests, held until the matching done_o
//   grant_o       out  [N_REQ] one-hot grant, high for the whole transaction
//   done_o        out  [N_REQ] one-cycle completion pulse
//   left_req_out  out  to async_man_m left_req_in
//   left_ack_in   in   from async_man_m left_ack_out (asynchronous)
//   set_out       out  to async_man_m set, tied low
//   reset_out     out  to async_man_m reset, active high
//   busy_o        out  high whenever the sequencer is not idle
//   timeout_o     out  sticky watchdog flag (ASYNC_ARB_TIMEOUT_EN only)
//
// Optional feature macro: ASYNC_ARB_TIMEOUT_EN
//   Adds the TIMEOUT_CYCLES parameter, a per-phase watchdog, an ERR state and
//   the timeout_o port. Without it the sequencer waits indefinitely for ack.

module async_arb_m #(
    parameter int N_REQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int INIT_CYCLES = 8
`ifdef ASYNC_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [N_REQ-1:0] done_o,
    output logic             left_req_out,
    input  logic             left_ack_in,
    output logic             set_out,
    output logic             reset_out,
    output logic             busy_o
`ifdef ASYNC_ARB_TIMEOUT_EN
    ,
    output logic             timeout_o
`endif
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
`ifdef ASYNC_ARB_TIMEOUT_EN
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RISE,
        ST_FALL
`ifdef ASYNC_ARB_TIMEOUT_EN
        ,
        ST_ERR
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               left_req_q, left_req_d;
    logic               reset_q, reset_d;
    logic               busy_q, busy_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               ack_s;
`ifdef ASYNC_ARB_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // Round-robin pick: rotate requests so the pointer lands on bit 0, find
    // the lowest set bit, then add the pointer back modulo N_REQ.
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               any_req;
    int                 pick_off;
    int                 pick_sum;
    logic [PTR_W-1:0]   pick;
    logic [N_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]   sel_next;

    assign ack_s   = sync_q[SYNC_STAGES-1];
    assign req_dbl = {req_i, req_i} >> rr_q;
    assign req_rot = req_dbl[N_REQ-1:0];
    assign any_req = |req_i;

    always_comb begin
        pick_off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_off = i;
            end
        end
        pick_sum = int'(rr_q) + pick_off;
        if (pick_sum >= N_REQ) begin
            pick_sum = pick_sum - N_REQ;
        end
        pick        = PTR_W'(pick_sum);
        pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
    end

    assign sel_next = (sel_q == PTR_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rr_d       = rr_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        done_d     = '0;
        left_req_d = left_req_q;
        reset_d    = reset_q;
`ifdef ASYNC_ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_INIT: begin
                reset_d    = 1'b1;
                grant_d    = '0;
                left_req_d = 1'b0;
                if (init_cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    init_cnt_d = '0;
                    reset_d    = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (any_req) begin
                    sel_d      = pick;
                    grant_d    = pick_onehot;
                    left_req_d = 1'b1;
                    state_d    = ST_RISE;
`ifdef ASYNC_ARB_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            ST_RISE: begin
                if (ack_s) begin
                    left_req_d = 1'b0;
                    state_d    = ST_FALL;
`ifdef ASYNC_ARB_TIMEOUT_EN
                    to_cnt_d   = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    left_req_d = 1'b0;
                    grant_d    = '0;
                    timeout_d  = 1'b1;
                    state_d    = ST_ERR;
                end else begin
                    to_cnt_d   = to_cnt_q + 1'b1;
`endif
                end
            end
            ST_FALL: begin
                if (!ack_s) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    rr_d    = sel_next;
                    state_d = ST_IDLE;
`ifdef ASYNC_ARB_TIMEOUT_EN
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    left_req_d = 1'b0;
                    grant_d    = '0;
                    timeout_d  = 1'b1;
                    state_d    = ST_ERR;
                end else begin
                    to_cnt_d   = to_cnt_q + 1'b1;
`endif
                end
            end
`ifdef ASYNC_ARB_TIMEOUT_EN
            ST_ERR: begin
                // Abandon the transaction without done_o and re-reset the stage.
                left_req_d = 1'b0;
                grant_d    = '0;
                reset_d    = 1'b1;
                init_cnt_d = '0;
                state_d    = ST_INIT;
            end
`endif
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
                reset_d    = 1'b1;
                grant_d    = '0;
                left_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            rr_q       <= '0;
            sel_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            left_req_q <= 1'b0;
            reset_q    <= 1'b1;
            busy_q     <= 1'b1;
            sync_q     <= '0;
`ifdef ASYNC_ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            left_req_q <= left_req_d;
            reset_q    <= reset_d;
            busy_q     <= busy_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], left_ack_in};
`ifdef ASYNC_ARB_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign grant_o      = grant_q;
    assign done_o       = done_q;
    assign left_req_out = left_req_q;
    assign set_out      = 1'b0;
    assign reset_out    = reset_q;
    assign busy_o       = busy_q;
`ifdef ASYNC_ARB_TIMEOUT_EN
    assign timeout_o    = timeout_q;
`endif

endmodule

// File: tb/tb_async_arb_m.sv
// tb/tb_async_arb_m.sv - self-checking bench for async_arb_m with a transaction-timing model

module tb_async_arb_m;

    localparam int N    = 4;
    localparam int S    = 2;
    localparam int INIT = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] grant_o;
    logic [N-1:0] done_o;
    logic         left_req_out;
    logic         left_ack_in;
    logic         set_out;
    logic         reset_out;
    logic         busy_o;
`ifdef ASYNC_ARB_TIMEOUT_EN
    logic         timeout_o;
`endif

    int checks = 0;
    int failures = 0;

    // Handshake partner: ack follows left_req_out after ack_d clock edges.
    int         ack_d = 0;
    bit         ack_zero = 1'b0;
    logic [7:0] hist = '0;

    always #5 clk = ~clk;

    always @(posedge clk) hist <= {hist[6:0], left_req_out};

    assign left_ack_in = ack_zero ? 1'b0 :
                         (ack_d == 0) ? left_req_out : hist[(ack_d == 0) ? 0 : ack_d - 1];

    async_arb_m #(.N_REQ(N), .SYNC_STAGES(S), .INIT_CYCLES(INIT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (req_i),
        .grant_o      (grant_o),
        .done_o       (done_o),
        .left_req_out (left_req_out),
        .left_ack_in  (left_ack_in),
        .set_out      (set_out),
        .reset_out    (reset_out),
        .busy_o       (busy_o)
`ifdef ASYNC_ARB_TIMEOUT_EN
        ,
        .timeout_o    (timeout_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is in INIT until INIT edges with reset_n high have passed.
    // A transaction sampled at edge t0 with ack delay d raises left_req until
    // edge t0+d+S+1 (ack seen through S flops) and completes at t0+2d+2S+2.
    int           cyc = 0;
    int           init_edges = 0;
    bit           m_active = 1'b0;
    int           m_t0 = 0;
    int           m_sel = 0;
    int           m_d = 0;
    int           rr = 0;
    bit           model_on = 1'b0;
    logic [N-1:0] e_grant = '0;
    logic [N-1:0] e_done = '0;
    logic         e_lreq = 1'b0;
    logic         e_rst = 1'b1;
    logic         e_busy = 1'b1;

    always @(posedge clk) begin
        cyc++;
        e_done = '0;
        if (!reset_n) begin
            init_edges = 0;
            m_active   = 1'b0;
            rr         = 0;
        end else if (init_edges < INIT) begin
            init_edges++;
        end else if (!m_active) begin
            if (req_i != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_i[(rr + k) % N]) m_sel = (rr + k) % N;
                end
                m_active = 1'b1;
                m_t0     = cyc;
                m_d      = ack_d;
            end
        end else if (cyc == m_t0 + 2 * m_d + 2 * S + 2) begin
            m_active      = 1'b0;
            e_done[m_sel] = 1'b1;
            rr            = (m_sel + 1) % N;
        end
        e_rst   = (init_edges < INIT);
        e_busy  = e_rst || m_active;
        e_grant = '0;
        if (m_active) e_grant[m_sel] = 1'b1;
        e_lreq  = m_active && (cyc < m_t0 + m_d + S + 1);
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_grant", grant_o, e_grant);
            chk("m_done", done_o, e_done);
            chk("m_left_req", left_req_out, e_lreq);
            chk("m_reset_out", reset_out, e_rst);
            chk("m_busy", busy_o, e_busy);
            chk("m_set_out", set_out, 1'b0);
        end
    end

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        int n;
        n = 0;
        g = '0;
        while (grant_o == '0 && n < 300) begin
            sample();
            n++;
        end
        g = grant_o;
        if (g == '0) chk("wait_grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output logic [N-1:0] d);
        int n;
        n = 0;
        d = '0;
        while (n < 300) begin
            sample();
            n++;
            if (done_o != '0) break;
        end
        d = done_o;
        if (d == '0) chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [N-1:0] seq[$];
        logic [N-1:0] rr_exp[5];
        int           n;
        int           hi;
        int           rst_hold;

        reset_n = 1'b0;
        req_i   = '0;
        ack_d   = 0;
        repeat (3) sample();
        model_on = 1'b1;
        chk("rst_grant", grant_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_left_req", left_req_out, 0);
        chk("rst_reset_out", reset_out, 1);
        chk("rst_busy", busy_o, 1);

        // Release with a request already pending: no grant until INIT is over.
        reset_n = 1'b1;
        req_i   = 4'b0001;
        n = 0;
        while (reset_out && n < 40) begin
            sample();
            n++;
            if (reset_out) chk("init_no_grant", grant_o, 0);
        end
        chk("init_len", n, INIT);
        chk("init_exit_no_grant", grant_o, 0);
        sample();
        chk("first_grant", grant_o, 4'b0001);
        req_i = '0;
        wait_done(d);
        chk("first_done", d, 4'b0001);

        // Single request with an immediate ack: done on the 7th edge counting the sampling edge.
        sample();
        req_i = 4'b0010;
        n = 0;
        hi = 0;
        while (n < 50) begin
            sample();
            n++;
            if (n == 1) chk("single_grant", grant_o, 4'b0010);
            if (left_req_out) hi++;
            if (done_o != '0) break;
        end
        req_i = '0;
        chk("single_latency", n, 7);
        chk("single_done", done_o, 4'b0010);
        chk("single_req_high", hi, 3);
        sample();
        chk("single_done_once", done_o, 0);

        // Reset during RISE of requester 2.
        req_i = 4'b0100;
        wait_grant(g);
        chk("abort_grant", g, 4'b0100);
        chk("abort_in_rise", left_req_out, 1);
        reset_n = 1'b0;
        sample();
        chk("abort_left_req", left_req_out, 0);
        chk("abort_grant_clr", grant_o, 0);
        chk("abort_reset_out", reset_out, 1);
        reset_n = 1'b1;
        req_i = '0;
        n = 0;
        while (reset_out && n < 40) begin
            sample();
            n++;
        end
        chk("abort_reinit_len", n, INIT);

        // All requesting: strict round robin from pointer 0 after the reset.
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(d);
            seq.push_back(d);
        end
        req_i = '0;
        for (int k = 0; k < 5; k++) chk("rr_order", seq[k], rr_exp[k]);

        // Requester 1 drops its request mid-RISE; it still completes, pointer moves to 2.
        sample();
        req_i = 4'b0010;
        wait_grant(g);
        chk("drop_grant", g, 4'b0010);
        req_i = '0;
        wait_done(d);
        chk("drop_done", d, 4'b0010);
        req_i = 4'b1111;
        wait_grant(g);
        chk("drop_next_ptr", g, 4'b0100);
        req_i = '0;
        wait_done(d);
        chk("drop_next_done", d, 4'b0100);

        // Randomized traffic, ack delays and occasional resets, checked by the model.
        rst_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            sample();
            req_i = req_i & ~done_o;
            if (grant_o != '0 && $urandom_range(0, 15) == 0) req_i = req_i & ~grant_o;
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] && $urandom_range(0, 7) == 0) req_i[k] = 1'b1;
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n  = 1'b0;
                rst_hold = $urandom_range(1, 3);
            end
            if (!m_active && !left_req_out && hist == '0 && $urandom_range(0, 3) == 0)
                ack_d = $urandom_range(0, 3);
        end
        reset_n = 1'b1;
        req_i   = '0;
        repeat (40) sample();

`ifdef ASYNC_ARB_TIMEOUT_EN
        model_on = 1'b0;
        ack_zero = 1'b1;
        req_i    = 4'b0001;
        n  = 0;
        hi = 0;
        while (!timeout_o && n < 600) begin
            sample();
            n++;
            if (done_o != '0) hi++;
        end
        req_i = '0;
        chk("to_flag", timeout_o, 1);
        chk("to_left_req", left_req_out, 0);
        chk("to_grant", grant_o, 0);
        chk("to_no_done", hi, 0);
        sample();
        n = 0;
        while (reset_out && n < 40) begin
            n++;
            sample();
        end
        chk("to_reinit_len", n, INIT);
        repeat (5) sample();
        chk("to_sticky", timeout_o, 1);
        reset_n = 1'b0;
        sample();
        chk("to_cleared", timeout_o, 0);
        reset_n  = 1'b1;
        ack_zero = 1'b0;
        repeat (12) sample();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
